// File: rtl/usb_rx_pkg.sv
// Shared definitions for the USB receive path: FSM states, error codes and
// the SYNC pattern as seen in the decoded-bit shift register.
package usb_rx_pkg;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        RECV  = 2'd1,
        DRAIN = 2'd2
    } rx_state_e;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_STUFF = 2'b01;
    localparam logic [1:0] ERR_ALIGN = 2'b10;
    localparam logic [1:0] ERR_OVF   = 2'b11;

    // Newest decoded bit in the MSB: seven 0s followed by a final 1.
    localparam logic [7:0] SYNC_PATTERN = 8'b1000_0000;

    // History fill that can never form part of a SYNC (idle line decodes as 1s).
    localparam logic [6:0] HIST_IDLE = 7'h7F;

endpackage

// File: rtl/nrzi_decoder.sv
// NRZI decoder: a bit is 1 when the line level is unchanged from the previous
// valid bit. The reference level returns to idle J on every EOP.
module nrzi_decoder (
    input  logic gclk,
    input  logic reset,
    input  logic bit_in,
    input  logic bit_valid,
    input  logic eop,
    output logic dbit,
    output logic dbit_valid
);

    logic prev_level_q;
    logic prev_level_d;

    always_comb begin
        prev_level_d = prev_level_q;
        if (eop) begin
            prev_level_d = 1'b1;
        end else if (bit_valid) begin
            prev_level_d = bit_in;
        end
    end

    always_ff @(posedge gclk) begin
        if (reset) begin
            prev_level_q <= 1'b1;
        end else begin
            prev_level_q <= prev_level_d;
        end
    end

    // EOP takes precedence, so a bit arriving with it is discarded.
    assign dbit       = ~(bit_in ^ prev_level_q);
    assign dbit_valid = bit_valid & ~eop;

endmodule

// File: rtl/rx_nrzi_unstuff.sv
// Receive stage: NRZI decode, SYNC hunt, bit unstuffing and LSB-first byte
// assembly, producing a byte stream framed by sop/end/error strobes.
module rx_nrzi_unstuff #(
    parameter int MAX_BYTES   = 1027,
    parameter int STUFF_LIMIT = 6,
    parameter int CNT_W       = 11
) (
    input  logic             gclk,
    input  logic             reset,
    input  logic             rx_bit,
    input  logic             rx_bit_valid,
    input  logic             rx_eop,
    output logic [7:0]       rx_data,
    output logic             rx_data_valid,
    output logic             rx_active,
    output logic             rx_sop,
    output logic             rx_pkt_end,
    output logic             rx_err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] byte_count
);

    import usb_rx_pkg::*;

    localparam int ONES_W = $clog2(STUFF_LIMIT + 1);

    logic dbit;
    logic dbit_valid;

    nrzi_decoder u_nrzi_decoder (
        .gclk       (gclk),
        .reset      (reset),
        .bit_in     (rx_bit),
        .bit_valid  (rx_bit_valid),
        .eop        (rx_eop),
        .dbit       (dbit),
        .dbit_valid (dbit_valid)
    );

    rx_state_e        state_q,      state_d;
    logic [6:0]       hist_q,       hist_d;
    logic [6:0]       shreg_q,      shreg_d;
    logic [2:0]       bit_cnt_q,    bit_cnt_d;
    logic [ONES_W-1:0] ones_cnt_q,  ones_cnt_d;
    logic [1:0]       err_latch_q,  err_latch_d;
    logic [CNT_W-1:0] byte_count_q, byte_count_d;
    logic [7:0]       rx_data_q,    rx_data_d;
    logic             data_valid_q, data_valid_d;
    logic             active_q,     active_d;
    logic             sop_q,        sop_d;
    logic             pkt_end_q,    pkt_end_d;
    logic             err_q,        err_d;
    logic [1:0]       err_code_q,   err_code_d;

    logic [7:0] sync_window;
    logic [7:0] byte_full;

    // Both windows are the stored bits plus the bit arriving this cycle.
    assign sync_window = {dbit, hist_q};
    assign byte_full   = {dbit, shreg_q};

    always_comb begin
        state_d      = state_q;
        hist_d       = hist_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        ones_cnt_d   = ones_cnt_q;
        err_latch_d  = err_latch_q;
        byte_count_d = byte_count_q;
        rx_data_d    = rx_data_q;
        active_d     = active_q;
        data_valid_d = 1'b0;
        sop_d        = 1'b0;
        pkt_end_d    = 1'b0;
        err_d        = 1'b0;
        err_code_d   = ERR_NONE;

        case (state_q)
            HUNT: begin
                if (rx_eop) begin
                    hist_d = HIST_IDLE;
                end else if (dbit_valid) begin
                    hist_d = sync_window[7:1];
                    if (sync_window == SYNC_PATTERN) begin
                        state_d      = RECV;
                        hist_d       = HIST_IDLE;
                        sop_d        = 1'b1;
                        active_d     = 1'b1;
                        bit_cnt_d    = 3'd0;
                        byte_count_d = '0;
                        ones_cnt_d   = ONES_W'(1);
                        err_latch_d  = ERR_NONE;
                    end
                end
            end

            RECV: begin
                if (rx_eop) begin
                    state_d   = HUNT;
                    active_d  = 1'b0;
                    pkt_end_d = 1'b1;
                    if (bit_cnt_q != 3'd0) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_ALIGN;
                    end
                end else if (dbit_valid) begin
                    if (ones_cnt_q == ONES_W'(STUFF_LIMIT)) begin
                        if (dbit) begin
                            err_latch_d = ERR_STUFF;
                            state_d     = DRAIN;
                        end else begin
                            ones_cnt_d = '0;
                        end
                    end else begin
                        ones_cnt_d = dbit ? ones_cnt_q + ONES_W'(1) : '0;
                        shreg_d    = byte_full[7:1];
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        // Last bit of a byte: deliver it unless the packet is already full.
                        if (bit_cnt_q == 3'd7) begin
                            if (byte_count_q == CNT_W'(MAX_BYTES)) begin
                                err_latch_d = ERR_OVF;
                                state_d     = DRAIN;
                            end else begin
                                rx_data_d    = byte_full;
                                data_valid_d = 1'b1;
                                byte_count_d = byte_count_q + CNT_W'(1);
                            end
                        end
                    end
                end
            end

            DRAIN: begin
                if (rx_eop) begin
                    state_d    = HUNT;
                    active_d   = 1'b0;
                    pkt_end_d  = 1'b1;
                    err_d      = 1'b1;
                    err_code_d = err_latch_q;
                end
            end

            default: begin
                state_d = HUNT;
            end
        endcase
    end

    always_ff @(posedge gclk) begin
        if (reset) begin
            state_q      <= HUNT;
            hist_q       <= HIST_IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= 3'd0;
            ones_cnt_q   <= '0;
            err_latch_q  <= ERR_NONE;
            byte_count_q <= '0;
            rx_data_q    <= 8'h00;
            data_valid_q <= 1'b0;
            active_q     <= 1'b0;
            sop_q        <= 1'b0;
            pkt_end_q    <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= ERR_NONE;
        end else begin
            state_q      <= state_d;
            hist_q       <= hist_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            ones_cnt_q   <= ones_cnt_d;
            err_latch_q  <= err_latch_d;
            byte_count_q <= byte_count_d;
            rx_data_q    <= rx_data_d;
            data_valid_q <= data_valid_d;
            active_q     <= active_d;
            sop_q        <= sop_d;
            pkt_end_q    <= pkt_end_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_data_valid = data_valid_q;
    assign rx_active     = active_q;
    assign rx_sop        = sop_q;
    assign rx_pkt_end    = pkt_end_q;
    assign rx_err        = err_q;
    assign err_code      = err_code_q;
    assign byte_count    = byte_count_q;

endmodule

// File: tb/tb_rx_nrzi_unstuff.sv
// Self-checking bench for rx_nrzi_unstuff: an NRZI/bit-stuffing encoder drives
// packets while a scoreboard queue holds the strobes the receiver must produce.
module tb_rx_nrzi_unstuff;

    localparam int MAX_BYTES   = 1027;
    localparam int STUFF_LIMIT = 6;
    localparam int CNT_W       = 11;

    logic             gclk = 1'b0;
    logic             reset = 1'b1;
    logic             rx_bit = 1'b1;
    logic             rx_bit_valid = 1'b0;
    logic             rx_eop = 1'b0;
    logic [7:0]       rx_data;
    logic             rx_data_valid;
    logic             rx_active;
    logic             rx_sop;
    logic             rx_pkt_end;
    logic             rx_err;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] byte_count;

    rx_nrzi_unstuff #(
        .MAX_BYTES   (MAX_BYTES),
        .STUFF_LIMIT (STUFF_LIMIT),
        .CNT_W       (CNT_W)
    ) dut (
        .gclk          (gclk),
        .reset         (reset),
        .rx_bit        (rx_bit),
        .rx_bit_valid  (rx_bit_valid),
        .rx_eop        (rx_eop),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .rx_active     (rx_active),
        .rx_sop        (rx_sop),
        .rx_pkt_end    (rx_pkt_end),
        .rx_err        (rx_err),
        .err_code      (err_code),
        .byte_count    (byte_count)
    );

    always #5 gclk = ~gclk;

    typedef enum int {EV_SOP = 0, EV_BYTE = 1, EV_END = 2} ev_kind_e;

    typedef struct {
        ev_kind_e   kind;
        logic [7:0] data;
        logic [1:0] code;
        int         count;
    } ev_t;

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        int         nbytes;
        int         extra;
        logic [1:0] code;
    } vec_t;

    ev_t  exp_q[$];
    int   errors = 0;
    int   checks = 0;
    logic tb_level = 1'b1;
    int   tb_ones = 0;
    int   gap = 3;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic take_event(input ev_kind_e kind, output ev_t ev, output bit ok);
        ok = 1'b0;
        ev.kind = kind;
        ev.data = 8'h00;
        ev.code = 2'b00;
        ev.count = 0;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_event: got kind %0d expected none at %0t", kind, $time);
        end else begin
            ev = exp_q.pop_front();
            check_output("event_kind", kind, ev.kind);
            ok = (ev.kind == kind);
        end
    endtask

    // Scoreboard side: every strobe from the DUT must match the head of the queue.
    always @(negedge gclk) begin
        ev_t ev;
        bit  ok;
        if (!reset) begin
            if (rx_data_valid && rx_pkt_end) check_output("valid_end_overlap", 1, 0);
            if (rx_sop) begin
                take_event(EV_SOP, ev, ok);
                check_output("sop_active", rx_active, 1);
                check_output("sop_count", byte_count, 0);
            end
            if (rx_data_valid) begin
                take_event(EV_BYTE, ev, ok);
                if (ok) check_output("byte_data", rx_data, ev.data);
                check_output("byte_active", rx_active, 1);
            end
            if (rx_pkt_end) begin
                take_event(EV_END, ev, ok);
                if (ok) begin
                    check_output("end_err", rx_err, (ev.code != 2'b00));
                    check_output("end_code", err_code, ev.code);
                    check_output("end_count", byte_count, ev.count);
                end
                check_output("end_active", rx_active, 0);
            end
        end
    end

    task automatic push_ev(input ev_kind_e kind, input logic [7:0] data,
                           input logic [1:0] code, input int count);
        ev_t ev;
        ev.kind  = kind;
        ev.data  = data;
        ev.code  = code;
        ev.count = count;
        exp_q.push_back(ev);
    endtask

    task automatic drive_level(input logic lvl);
        rx_bit = lvl;
        rx_bit_valid = 1'b1;
        @(negedge gclk);
        rx_bit_valid = 1'b0;
        repeat (gap) @(negedge gclk);
    endtask

    // A decoded 0 toggles the line, a decoded 1 holds it.
    task automatic send_raw(input logic d);
        if (!d) tb_level = ~tb_level;
        drive_level(tb_level);
    endtask

    task automatic send_bit(input logic d);
        send_raw(d);
        tb_ones = d ? tb_ones + 1 : 0;
        if (tb_ones == STUFF_LIMIT) begin
            send_raw(1'b0);
            tb_ones = 0;
        end
    endtask

    task automatic send_sync();
        push_ev(EV_SOP, 8'h00, 2'b00, 0);
        for (int i = 0; i < 7; i++) send_raw(1'b0);
        send_raw(1'b1);
        tb_ones = 1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit expect_out);
        if (expect_out) push_ev(EV_BYTE, b, 2'b00, 0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        repeat (3) @(negedge gclk);
        while (exp_q.size() != 0 && n < 64) begin
            @(negedge gclk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s: %0d expected events still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic send_eop(input string name);
        rx_eop = 1'b1;
        @(negedge gclk);
        rx_eop = 1'b0;
        tb_level = 1'b1;
        tb_ones = 0;
        wait_drain(name);
    endtask

    task automatic apply_stimulus(input vec_t v);
        gap = 3;
        send_sync();
        send_byte(v.b0, 1'b1);
        if (v.nbytes > 1) send_byte(v.b1, 1'b1);
        for (int k = 0; k < v.extra; k++) send_bit(k[0] == 1'b0);
        push_ev(EV_END, 8'h00, v.code, v.nbytes);
        send_eop("table_packet");
    endtask

    vec_t vecs[4];

    initial begin
        vecs[0] = '{b0: 8'hD2, b1: 8'h5A, nbytes: 2, extra: 0, code: 2'b00};
        vecs[1] = '{b0: 8'hFF, b1: 8'h01, nbytes: 2, extra: 0, code: 2'b00};
        vecs[2] = '{b0: 8'hC3, b1: 8'h00, nbytes: 1, extra: 3, code: 2'b10};
        vecs[3] = '{b0: 8'h00, b1: 8'hFF, nbytes: 2, extra: 0, code: 2'b00};

        repeat (4) @(negedge gclk);
        check_output("reset_active", rx_active, 0);
        check_output("reset_data", rx_data, 8'h00);
        check_output("reset_strobes", {rx_sop, rx_data_valid, rx_pkt_end, rx_err}, 4'b0000);
        check_output("reset_code", err_code, 2'b00);
        check_output("reset_count", byte_count, 0);
        reset = 1'b0;
        repeat (2) @(negedge gclk);

        for (int i = 0; i < 4; i++) apply_stimulus(vecs[i]);

        // Stuff error: a sixth 1 after SYNC's final 1, then junk until EOP.
        gap = 3;
        send_sync();
        for (int i = 0; i < 7; i++) send_raw(1'b1);
        for (int i = 0; i < 20; i++) send_raw(1'($urandom_range(0, 1)));
        push_ev(EV_END, 8'h00, 2'b01, 0);
        send_eop("stuff_error");

        // Hunt robustness: EOP must wipe a partial SYNC and emit nothing.
        for (int i = 0; i < 5; i++) send_raw(1'b0);
        send_eop("hunt_eop");
        send_raw(1'b0);
        send_raw(1'b0);
        send_raw(1'b1);
        push_ev(EV_SOP, 8'h00, 2'b00, 0);
        gap = 7;
        for (int i = 0; i < 4; i++) send_raw(1'b0);
        gap = 2;
        for (int i = 0; i < 3; i++) send_raw(1'b0);
        gap = 9;
        send_raw(1'b1);
        tb_ones = 1;
        gap = 3;
        send_byte(8'h3C, 1'b1);
        push_ev(EV_END, 8'h00, 2'b00, 1);
        send_eop("hunt_split_sync");

        // Reset after 12 bits: the aborted packet must never report an end.
        send_sync();
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        reset = 1'b1;
        repeat (2) @(negedge gclk);
        check_output("midreset_active", rx_active, 0);
        check_output("midreset_data", rx_data, 8'h00);
        check_output("midreset_count", byte_count, 0);
        reset = 1'b0;
        tb_level = 1'b1;
        tb_ones = 0;
        repeat (2) @(negedge gclk);
        send_sync();
        send_byte(8'hA5, 1'b1);
        push_ev(EV_END, 8'h00, 2'b00, 1);
        send_eop("after_reset");

        // Overflow: one byte past the limit is swallowed and flagged.
        gap = 0;
        send_sync();
        for (int i = 0; i <= MAX_BYTES; i++) send_byte(8'(i), i < MAX_BYTES);
        push_ev(EV_END, 8'h00, 2'b11, MAX_BYTES);
        send_eop("overflow");

        repeat (5) @(negedge gclk);
        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
